// File: rtl/mux_owner_arbiter.sv
// Two-requester round-robin arbiter driving the sel/enable pins of the shared 2:1 mux.
// Every ownership change passes through one disabled turnaround cycle, and an optional hold limit lets a waiting requester preempt the owner.
module mux_owner_arbiter #(
   parameter int CNT_W    = 5,
   parameter int MAX_HOLD = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic req_0,
   input  logic req_1,
   input  logic release_0,
   input  logic release_1,
   output logic grant_0,
   output logic grant_1,
   output logic mux_sel,
   output logic mux_enable,
   output logic busy,
   output logic timeout
);

   typedef enum logic [1:0] {
      IDLE,
      TURN,
      OWN
   } state_t;

   // hold_cnt reads 0 in the first OWN cycle, so MAX_HOLD-1 marks the last allowed cycle
   localparam logic [CNT_W-1:0] HOLD_LIM = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_t           state, state_nx;
   logic             owner, owner_nx;
   logic             last, last_nx;
   logic [CNT_W-1:0] hold_cnt, hold_cnt_nx;
   logic             sel_nx;
   logic             timeout_nx;

   logic req_own, req_oth, rel_own;
   logic exit_norm, exit_pre;

   assign req_own   = owner ? req_1 : req_0;
   assign req_oth   = owner ? req_0 : req_1;
   assign rel_own   = owner ? release_1 : release_0;
   assign exit_norm = rel_own | ~req_own;
   assign exit_pre  = (MAX_HOLD != 0) && (hold_cnt >= HOLD_LIM) && req_oth;

   always_comb begin
      state_nx    = state;
      owner_nx    = owner;
      last_nx     = last;
      hold_cnt_nx = hold_cnt;
      sel_nx      = mux_sel;
      timeout_nx  = 1'b0;
      case (state)
         IDLE: begin
            if (req_0 | req_1) begin
               owner_nx = (req_0 & req_1) ? ~last : req_1;
               sel_nx   = owner_nx;
               state_nx = TURN;
            end
         end
         TURN: begin
            state_nx    = OWN;
            hold_cnt_nx = '0;
         end
         OWN: begin
            if (exit_norm | exit_pre) begin
               last_nx    = owner;
               timeout_nx = exit_pre & ~exit_norm;
               if (req_oth) begin
                  owner_nx = ~owner;
                  sel_nx   = ~owner;
                  state_nx = TURN;
               end else begin
                  state_nx = IDLE;
               end
            end else if (hold_cnt != CNT_MAX) begin
               hold_cnt_nx = hold_cnt + CNT_W'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Outputs are registered from the next-state values so they line up with the state they describe
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last       <= 1'b1;
         hold_cnt   <= '0;
         grant_0    <= 1'b0;
         grant_1    <= 1'b0;
         mux_sel    <= 1'b0;
         mux_enable <= 1'b0;
         busy       <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         state      <= state_nx;
         owner      <= owner_nx;
         last       <= last_nx;
         hold_cnt   <= hold_cnt_nx;
         grant_0    <= (state_nx == OWN) && !owner_nx;
         grant_1    <= (state_nx == OWN) && owner_nx;
         mux_sel    <= sel_nx;
         mux_enable <= (state_nx == OWN);
         busy       <= (state_nx != IDLE);
         timeout    <= timeout_nx;
      end
   end

endmodule

// File: tb/tb_mux_owner_arbiter.sv
// Randomized plus directed bench for mux_owner_arbiter: two instances (hold limit 4 and preemption off)
// share one stimulus stream and are scored cycle by cycle against a transaction-level reference model.
module tb_mux_owner_arbiter;

   logic clock = 1'b0;
   logic reset;
   logic req_0, req_1, release_0, release_1;

   logic g0_a, g1_a, sel_a, en_a, busy_a, to_a;
   logic g0_b, g1_b, sel_b, en_b, busy_b, to_b;

   always #5 clock = ~clock;

   mux_owner_arbiter #(.CNT_W(5), .MAX_HOLD(4)) dut4 (
      .clock(clock), .reset(reset),
      .req_0(req_0), .req_1(req_1), .release_0(release_0), .release_1(release_1),
      .grant_0(g0_a), .grant_1(g1_a), .mux_sel(sel_a), .mux_enable(en_a),
      .busy(busy_a), .timeout(to_a)
   );

   mux_owner_arbiter #(.CNT_W(5), .MAX_HOLD(0)) dut0 (
      .clock(clock), .reset(reset),
      .req_0(req_0), .req_1(req_1), .release_0(release_0), .release_1(release_1),
      .grant_0(g0_b), .grant_1(g1_b), .mux_sel(sel_b), .mux_enable(en_b),
      .busy(busy_b), .timeout(to_b)
   );

   // Reference model: who owns the mux, whether we are in the turnaround gap,
   // and how many cycles the current owner has held it.
   typedef struct {
      bit turning;
      bit owning;
      int o;
      int last;
      int held;
      bit sel;
      bit tmo;
   } m_t;

   typedef struct packed {
      logic [5:0] e4;
      logic [5:0] e0;
   } exp_t;

   exp_t sb_q[$];
   m_t   m4, m0;
   int   checks = 0;
   int   passed = 0;
   bit   sb_en  = 0;
   logic prev_en  = 1'b0;
   logic prev_sel = 1'b0;
   bit   cur_r0, cur_r1;

   function automatic m_t model_reset();
      m_t m;
      m.turning = 0; m.owning = 0; m.o = 0; m.last = 1;
      m.held = 0; m.sel = 0; m.tmo = 0;
      return m;
   endfunction

   function automatic m_t model_step(m_t m, int hold, bit r0, bit r1, bit rl0, bit rl1);
      m_t n;
      bit [1:0] req;
      bit [1:0] rel;
      bit norm, pre;
      req = {r1, r0};
      rel = {rl1, rl0};
      n = m;
      n.tmo = 0;
      if (m.owning) begin
         norm = rel[m.o] || !req[m.o];
         pre  = (hold != 0) && (m.held >= hold) && req[1 - m.o];
         if (norm || pre) begin
            n.last   = m.o;
            n.tmo    = pre && !norm;
            n.owning = 0;
            if (req[1 - m.o]) begin
               n.o       = 1 - m.o;
               n.turning = 1;
               n.sel     = (n.o == 1);
            end
         end else begin
            n.held = m.held + 1;
         end
      end else if (m.turning) begin
         n.turning = 0;
         n.owning  = 1;
         n.held    = 1;
      end else if (req != 2'b00) begin
         n.o       = (req == 2'b11) ? (1 - m.last) : (r1 ? 1 : 0);
         n.turning = 1;
         n.sel     = (n.o == 1);
      end
      return n;
   endfunction

   // Packed as {grant_0, grant_1, mux_sel, mux_enable, busy, timeout}
   function automatic logic [5:0] model_out(m_t m);
      return {m.owning && m.o == 0, m.owning && m.o == 1, m.sel, m.owning,
              m.owning || m.turning, m.tmo};
   endfunction

   task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
   endtask

   task automatic apply_reset_now();
      exp_t e;
      reset = 1'b1;
      m4 = model_reset();
      m0 = model_reset();
      e.e4 = model_out(m4);
      e.e0 = model_out(m0);
      sb_q.delete();
      sb_q.push_back(e);
   endtask

   task automatic step(input bit r0, input bit r1, input bit rl0, input bit rl1);
      exp_t e;
      req_0 = r0; req_1 = r1; release_0 = rl0; release_1 = rl1;
      @(posedge clock);
      if (reset) begin
         m4 = model_reset();
         m0 = model_reset();
      end else begin
         m4 = model_step(m4, 4, r0, r1, rl0, rl1);
         m0 = model_step(m0, 0, r0, r1, rl0, rl1);
      end
      e.e4 = model_out(m4);
      e.e0 = model_out(m0);
      sb_q.push_back(e);
      #1;
   endtask

   always @(negedge clock) begin
      if (sb_en) begin
         if (sb_q.size() == 0) begin
            checks++;
            $display("FAIL scoreboard_empty: got no expected entry, expected one at %0t", $time);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("dut4_outputs", {g0_a, g1_a, sel_a, en_a, busy_a, to_a}, e.e4);
            check("dut0_outputs", {g0_b, g1_b, sel_b, en_b, busy_b, to_b}, e.e0);
         end
         check("dut4_one_grant", 6'(g0_a & g1_a), 6'd0);
         check("dut0_one_grant", 6'(g0_b & g1_b), 6'd0);
         if (prev_en && en_a) check("dut4_sel_stable", 6'(sel_a), 6'(prev_sel));
         prev_en  <= en_a;
         prev_sel <= sel_a;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion, expected finish before time limit");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      req_0 = 1'b0; req_1 = 1'b0; release_0 = 1'b0; release_1 = 1'b0;
      @(posedge clock);
      #1;
      apply_reset_now();
      sb_en = 1;
      repeat (2) step(0, 0, 0, 0);
      reset = 1'b0;

      // single request, then release
      step(0, 0, 0, 0);
      repeat (6) step(1, 0, 0, 0);
      step(1, 0, 1, 0);
      repeat (3) step(0, 0, 0, 0);

      // three consecutive ties alternate 0, 1, 0
      for (int t = 0; t < 3; t++) begin
         repeat (4) step(1, 1, 0, 0);
         repeat (2) step(0, 0, 0, 0);
      end

      // handoff on release with the other requester waiting
      repeat (4) step(1, 0, 0, 0);
      repeat (2) step(1, 1, 0, 0);
      step(1, 1, 1, 0);
      repeat (4) step(0, 1, 0, 0);
      repeat (2) step(0, 0, 0, 0);

      // preemption: both held continuously
      repeat (2) step(1, 0, 0, 0);
      repeat (12) step(1, 1, 0, 0);
      repeat (3) step(0, 0, 0, 0);

      // release in the 4th OWN cycle coincides with preemption
      step(1, 0, 0, 0);
      repeat (4) step(1, 1, 0, 0);
      step(1, 1, 1, 0);
      repeat (4) step(0, 0, 0, 0);

      // asynchronous reset in the middle of an OWN cycle
      repeat (4) step(1, 0, 0, 0);
      #2;
      apply_reset_now();
      #1;
      check("dut4_async_reset", {3'b000, g0_a, en_a, busy_a}, 6'd0);
      check("dut0_async_reset", {3'b000, g0_b, en_b, busy_b}, 6'd0);
      step(0, 1, 0, 0);
      reset = 1'b0;
      repeat (4) step(0, 1, 0, 0);
      repeat (2) step(0, 0, 0, 0);

      // randomized traffic with occasional asynchronous resets
      cur_r0 = 0;
      cur_r1 = 0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 199) == 0) apply_reset_now();
         else if (reset) reset = 1'b0;
         if ($urandom_range(0, 3) == 0) cur_r0 = !cur_r0;
         if ($urandom_range(0, 3) == 0) cur_r1 = !cur_r1;
         step(cur_r0, cur_r1, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
      end

      reset = 1'b0;
      repeat (2) step(0, 0, 0, 0);
      @(negedge clock);
      #1;
      sb_en = 0;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/mux_owner_arbiter.md
# mux_owner_arbiter

Two-requester arbiter and sequencer for the decode gate array's 2:1 single-bit multiplexer. It grants the shared mux to one of two requesters and drives the mux's `sel` and `enable` inputs. It inserts a one-cycle turnaround with the mux disabled on every ownership change. It enforces round-robin fairness, with optional preemption after a bounded hold time.

## Interface
Parameters:
- `CNT_W`, default 5: width of the hold counter.
- `MAX_HOLD`, default 16: number of OWN cycles after which a waiting requester preempts the owner. 0 disables preemption. Must be at most 2^CNT_W−1.

Ports:
- `clock`  in  1: single system clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `req_0`, `req_1`  in  1 each: level request from requester 0 / 1.
- `release_0`, `release_1`  in  1 each: owner release strobe, sampled only from the current owner.
- `grant_0`, `grant_1`  out  1 each: registered grant. At most one is high at any time.
- `mux_sel`  out  1: drives mux `sel`. 0 selects `muxIn_0`, 1 selects `muxIn_1`.
- `mux_enable`  out  1: drives mux `enable`. When low, the mux output is forced to 0.
- `busy`  out  1: high in TURN and OWN.
- `timeout`  out  1: one-cycle pulse when the owner is preempted.

## Operation
- State machine `IDLE`, `TURN`, `OWN`. Internal state: `owner` (1 bit), `last` (1 bit, the last owner), and `hold_cnt` (CNT_W bits).
- All outputs are registered. Reset values:
  - State = IDLE, all grants 0, `mux_enable` 0, `mux_sel` 0, `busy` 0, `timeout` 0.
  - `owner` 0, `last` 1 (so requester 0 wins the first tie), `hold_cnt` 0.
- **IDLE.** Grants and enable are 0, and `mux_sel` holds its value.
  - If any req is high, pick a winner and go to TURN.
  - With one req high, that requester wins.
  - With both high, the requester ≠ `last` wins.
- **TURN.** Lasts exactly one cycle.
  - `mux_sel` = owner, `mux_enable` 0, grants 0.
  - Next state is always OWN.
  - Requests are not re-evaluated in TURN. A winner whose req has dropped still passes through OWN, then exits next cycle by the req-drop rule.
- **OWN.**
  - `grant_owner` = 1, `mux_enable` = 1, `mux_sel` = owner.
  - `hold_cnt` clears on entry, then increments each OWN cycle and saturates at all-ones.
- **Exit conditions from OWN**, evaluated at each edge:
  - (a) `release_owner` is high, or
  - (b) `req_owner` is low, or
  - (c) MAX_HOLD ≠ 0, `hold_cnt` ≥ MAX_HOLD−1, and the other req is high (preemption).
  - If (a) or (b) holds together with (c), the exit counts as a normal release: no `timeout`.
- **On exit:**
  - `last` ← owner. Grants and `mux_enable` drop at that edge.
  - If the other req is high: owner ← other, go directly to TURN.
  - Otherwise go to IDLE.
  - `timeout` pulses only for an exit caused by (c) alone.
- **Ignored inputs:** the non-owner's release is ignored. The non-owner's req has no effect during OWN except to arm preemption and the handoff.
- **Reset mid-operation:** grant and enable fall asynchronously. The mux output goes to 0 with no glitch to the other input, because `mux_sel` resets to 0 while enable is already 0.

## Timing
- Request to grant: req seen at edge n → TURN after edge n → grant and enable high after edge n+1. Grant latency is 2 cycles.
- Release to handoff: release seen at edge m → grant drops after m. The other grant rises after m+1, giving exactly one disabled turnaround cycle.
- `mux_sel` changes only on entry to TURN, never while `mux_enable` is high.
- Preemption with MAX_HOLD = H: the owner is held for exactly H OWN cycles, then `timeout` is high for one cycle, coincident with TURN.

## Test plan
- **Single request:** reset, then `req_0`=1 at cycle 2 → TURN in cycle 3 (sel 0, en 0), `grant_0`=1 and en=1 from cycle 4; `release_0` at cycle 8 → all low from cycle 9, state IDLE.
- **Tie-breaking:** both reqs high from reset release → requester 0 granted first. Repeat the tie after release → requester 1 wins. Third tie → requester 0 wins.
- **Handoff:** owner 0 active, `req_1` held high, `release_0` pulsed → `grant_0` low, then one cycle with en=0 and sel=1, then `grant_1`=1. The two grants are never both high.
- **Preemption:** MAX_HOLD=4, `req_0` held continuously, `req_1` raised → `grant_0` high for exactly 4 cycles, `timeout`=1 for one cycle, then `grant_1`. With MAX_HOLD=0 the same stimulus never grants 1.
- **Release coinciding with preemption:** `release_0` asserted in the 4th OWN cycle → handoff occurs with `timeout`=0.
- **Asynchronous reset:** `reset` asserted mid-cycle during OWN → grant, `mux_enable` and `busy` fall before the next clock edge. After release of `reset` with `req_1` high → the grant goes to requester 1 after 2 cycles.
